mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
Shares one multiplication_top instance among N requesters using round-robin arbitration. Captures the winner's operands and drives the multiplier's start/ready handshake. Returns the 129-bit product to the granted requester with a one-cycle response pulse. Sits between the client engines and the single multiplier datapath.

Parameters:
N, 4, number of requesters (2..8)
W, 64, operand width; must match multiplication_top
RW, 2*W+1, result width (129 at default)
TIMEOUT, 1024, max cycles spent in the WAIT states before aborting (counter width clog2(TIMEOUT)+1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  N  per-requester request level; held until that requester's resp_valid
a_bus  input  N*W  packed operand A; requester i occupies bits [i*W +: W]
b_bus  input  N*W  packed operand B, same packing
resp_valid  output  N  one-hot, one-cycle pulse to the served requester
resp_err  output  1  qualifies resp_valid: 1 means timeout abort, result invalid
resp_result  output  RW  product; valid while resp_valid != 0
busy  output  1  high in every state except IDLE
grant_id  output  clog2(N)  index of the current or last served requester
mul_a  output  W  operand A to multiplier (registered)
mul_b  output  W  operand B to multiplier (registered)
mul_start  output  1  start to multiplier (registered)
mul_ready  input  1  ready level from multiplier
mul_result  input  RW  result from multiplier

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=IDLE; all outputs 0; round-robin pointer=0; timeout counter=0. Reset mid-operation aborts silently: no resp_valid is issued. The multiplier shares the same reset.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if req!=0, pick the first set bit at or after the pointer, wrapping modulo N. On that edge, latch a_bus/b_bus slices into mul_a/mul_b, set grant_id, clear the counter, go to ISSUE. If req==0, stay.
- ISSUE: mul_start=1 for exactly this one cycle. Next state is WAIT_BUSY.
- WAIT_BUSY: mul_start=0. Wait for mul_ready==0, which the multiplier asserts as its acknowledgement. Then go to WAIT_DONE.
- WAIT_DONE: wait for mul_ready==1. On that edge, capture mul_result into resp_result and go to RESP.
- RESP: resp_valid[grant_id]=1 for one cycle. Pointer becomes (grant_id+1) mod N. Next state is IDLE.
- Timeout: the counter increments each cycle in WAIT_BUSY/WAIT_DONE. When it reaches TIMEOUT-1, go to RESP with resp_err=1 and resp_result=0.
- resp_err is 0 on normal responses. It is meaningful only while resp_valid!=0.
- Operand stability: mul_a/mul_b stay constant from grant until the return to IDLE.
  - Changes on a_bus/b_bus after grant are ignored.
  - Dropping req after grant does not cancel the op; the response still pulses.
- Requester protocol: drop req on the edge where resp_valid is sampled high. If req stays high, it re-enters arbitration in IDLE at lowest priority.
- Minimum latency, req to resp_valid: 4 cycles plus multiplier compute time. There is always exactly one IDLE cycle between operations.
- Simultaneous requests: only one is granted. The others wait; no request is lost while req is held.
- Starvation bound: a held request is served within N operations.
- grant_id holds its last value in IDLE.
- mul_result is sampled only in WAIT_DONE.

Test Plan:
- Single op: req=0001, a0=17, b0=27 → one mul_start pulse, mul_a=17, mul_b=27; later resp_valid=0001, resp_result=459, resp_err=0.
- All-request fairness: req=1111 held continuously, operands a_i=i+2, b_i=10 → grant order 0,1,2,3,0; each resp_result equals (i+2)*10.
- Pointer wrap: serve requester 3, then req=1001 → requester 0 granted next; then req=1001 again → requester 3.
- Operand change after grant: a0 switched from 5 to 99 in the ISSUE cycle → resp_result=5*b0; mul_a stays 5 throughout.
- Timeout: mul_ready tied 1 (never acknowledges) → after TIMEOUT cycles, resp_valid pulses with resp_err=1, resp_result=0; FSM returns to IDLE.
- Reset mid-op: assert reset during WAIT_DONE → next cycle busy=0, mul_start=0, resp_valid=0, pointer=0; a new req=0010 afterward is granted normally.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares a single multiplier among N requesters.
// One operation is in flight at a time. The granted requester's operands are
// frozen into mul_a/mul_b. The multiplier is started with a one-cycle pulse,
// and its ready level is tracked through acknowledge (low) and completion
// (high). The product returns with a one-hot, one-cycle resp_valid pulse.
// A watchdog counter aborts with resp_err if the multiplier stalls.
module mult_share_arbiter #(
    parameter int N       = 4,
    parameter int W       = 64,
    parameter int RW      = 2*W+1,
    parameter int TIMEOUT = 1024,
    localparam int GW     = (N > 1) ? $clog2(N) : 1,
    localparam int CW     = $clog2(TIMEOUT) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  a_bus,
    input  logic [N*W-1:0]  b_bus,
    output logic [N-1:0]    resp_valid,
    output logic            resp_err,
    output logic [RW-1:0]   resp_result,
    output logic            busy,
    output logic [GW-1:0]   grant_id,
    output logic [W-1:0]    mul_a,
    output logic [W-1:0]    mul_b,
    output logic            mul_start,
    input  logic            mul_ready,
    input  logic [RW-1:0]   mul_result
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [GW-1:0]   r_ptr;
    logic [GW-1:0]   r_grant;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_mul_a;
    logic [W-1:0]    r_mul_b;
    logic            r_mul_start;
    logic [N-1:0]    r_resp_valid;
    logic            r_resp_err;
    logic [RW-1:0]   r_resp_result;

    logic [GW-1:0]   w_pick;
    logic            w_grant_load;
    logic            w_done_ok;
    logic            w_done_err;
    logic            w_in_wait;
    logic            w_cnt_expired;
    logic [GW-1:0]   w_ptr_nxt;

    // First requester at or after the pointer, wrapping modulo N. Scanning
    // from the far end down lets the nearest set bit overwrite the rest.
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] r,
                                              input logic [GW-1:0] p);
        logic [GW-1:0] sel;
        int            idx;
        sel = p;
        for (int k = N-1; k >= 0; k--) begin
            idx = (int'(p) + k) % N;
            if (r[idx]) begin
                sel = GW'(idx);
            end
        end
        return sel;
    endfunction

    // One-hot response strobe for the served requester.
    function automatic logic [N-1:0] onehot(input logic [GW-1:0] g);
        logic [N-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    assign w_pick        = rr_pick(req, r_ptr);
    assign w_in_wait     = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    assign w_cnt_expired = (r_cnt == CW'(TIMEOUT-1));
    assign w_ptr_nxt     = (r_grant == GW'(N-1)) ? '0 : r_grant + GW'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the one-cycle event strobes that steer the datapath.
    // In WAIT_BUSY the watchdog wins. In WAIT_DONE a result that is already
    // present is returned even on the last allowed cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_load = 1'b0;
        w_done_ok    = 1'b0;
        w_done_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_grant_load = 1'b1;
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (w_cnt_expired) begin
                    w_done_err  = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (!mul_ready) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (mul_ready) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_cnt_expired) begin
                    w_done_err  = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Watchdog counter: cleared at grant, advances only while waiting on the multiplier.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_grant_load) begin
            r_cnt <= '0;
        end else if (w_in_wait) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Grant capture: operands and winner index are frozen until the next grant,
    // so later bus activity cannot disturb an operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_grant <= '0;
        end else if (w_grant_load) begin
            r_mul_a <= a_bus[int'(w_pick)*W +: W];
            r_mul_b <= b_bus[int'(w_pick)*W +: W];
            r_grant <= w_pick;
        end
    end

    // Start pulse: high exactly during the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul_start <= 1'b0;
        end else begin
            r_mul_start <= w_grant_load;
        end
    end

    // Response capture. The product is sampled only when completing from WAIT_DONE.
    // An abort returns zero with the error flag set. The strobe lasts one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid  <= '0;
            r_resp_err    <= 1'b0;
            r_resp_result <= '0;
        end else begin
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            if (w_done_ok) begin
                r_resp_valid  <= onehot(r_grant);
                r_resp_result <= mul_result;
            end else if (w_done_err) begin
                r_resp_valid  <= onehot(r_grant);
                r_resp_err    <= 1'b1;
                r_resp_result <= '0;
            end
        end
    end

    // Round-robin pointer: the just-served requester drops to lowest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (r_state == S_RESP) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_result = r_resp_result;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_grant;
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign mul_start   = r_mul_start;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural multiplier stand-in.
module tb_mult_share_arbiter;

    localparam int N       = 4;
    localparam int W       = 64;
    localparam int RW      = 2*W+1;
    localparam int TIMEOUT = 1024;
    localparam int GW      = 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*W-1:0]  a_bus;
    logic [N*W-1:0]  b_bus;
    logic [N-1:0]    resp_valid;
    logic            resp_err;
    logic [RW-1:0]   resp_result;
    logic            busy;
    logic [GW-1:0]   grant_id;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic            mul_start;
    logic            mul_ready;
    logic [RW-1:0]   mul_result;

    mult_share_arbiter #(.N(N), .W(W), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .a_bus       (a_bus),
        .b_bus       (b_bus),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_result (resp_result),
        .busy        (busy),
        .grant_id    (grant_id),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_start   (mul_start),
        .mul_ready   (mul_ready),
        .mul_result  (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;

    int             exp_idx[$];
    logic [RW-1:0]  exp_res[$];
    logic           exp_err[$];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req_v, $time);
        end
    endtask

    // Multiplier stand-in: acknowledges start by dropping ready, computes for
    // 'lat' cycles, then raises ready with the product. 'stuck' models a
    // multiplier that never acknowledges.
    logic stuck;
    int   lat;
    int   m_cnt;
    always @(posedge clk) begin
        if (reset) begin
            mul_ready  <= 1'b1;
            mul_result <= '0;
            m_cnt      <= 0;
        end else if (!stuck) begin
            if (mul_start) begin
                mul_ready <= 1'b0;
                m_cnt     <= lat;
            end else if (m_cnt == 1) begin
                mul_ready  <= 1'b1;
                m_cnt      <= 0;
                mul_result <= {65'b0, mul_a} * {65'b0, mul_b};
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Monitor: every response pops and checks the oldest expectation.
    int            m_idx;
    logic [RW-1:0] m_res;
    logic          m_err;
    logic [N-1:0]  m_oh;
    always @(negedge clk) begin
        if (mul_start) n_start++;
        if (resp_valid != '0) begin
            if (exp_idx.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_unexpected: got resp_valid=%b, expected none", resp_valid);
            end else begin
                m_idx = exp_idx.pop_front();
                m_res = exp_res.pop_front();
                m_err = exp_err.pop_front();
                m_oh  = '0;
                m_oh[m_idx] = 1'b1;
                chk("resp_valid", RW'(resp_valid), RW'(m_oh));
                chk("resp_result", resp_result, m_res);
                chk("resp_err", RW'(resp_err), RW'(m_err));
            end
        end
    end

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_bus[i*W +: W] = a;
        b_bus[i*W +: W] = b;
    endtask

    task automatic expect_resp(input int idx, input logic [RW-1:0] res, input logic err);
        exp_idx.push_back(idx);
        exp_res.push_back(res);
        exp_err.push_back(err);
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mul_start) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_start: got no mul_start in %0d cycles, expected one", cyc);
    endtask

    task automatic wait_resp(input int bound, input logic chk_a, input logic [W-1:0] a_exp,
                             output int cyc);
        cyc = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (chk_a) chk("mul_a_hold", RW'(mul_a), RW'(a_exp));
            if (resp_valid != '0) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_resp: got no resp_valid in %0d cycles, expected one", cyc);
    endtask

    int c;
    int s0;
    int ord[5]             = '{0, 1, 2, 3, 0};
    logic [RW-1:0] fres[5] = '{20, 30, 40, 50, 20};

    initial begin
        reset = 1'b1;
        req   = '0;
        a_bus = '0;
        b_bus = '0;
        stuck = 1'b0;
        lat   = 3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", RW'(busy), 0);
        chk("rst_mul_start", RW'(mul_start), 0);
        chk("rst_resp_valid", RW'(resp_valid), 0);
        chk("rst_resp_err", RW'(resp_err), 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_mul_a", RW'(mul_a), 0);
        chk("rst_mul_b", RW'(mul_b), 0);
        chk("rst_grant_id", RW'(grant_id), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single op: 17*27 = 459
        set_op(0, 17, 27);
        expect_resp(0, 459, 1'b0);
        s0  = n_start;
        req = 4'b0001;
        wait_start(c);
        chk("t1_mul_a", RW'(mul_a), 17);
        chk("t1_mul_b", RW'(mul_b), 27);
        chk("t1_busy", RW'(busy), 1);
        wait_resp(100, 1'b0, '0, c);
        req = '0;
        chk("t1_latency", RW'(c), 5);
        @(negedge clk);
        chk("t1_start_pulses", RW'(n_start - s0), 1);
        chk("t1_idle", RW'(busy), 0);

        // Pointer wrap: pointer is 1 here; serve 3, then 1001 -> 0, then 1001 -> 3
        set_op(3, 6, 7);
        expect_resp(3, 42, 1'b0);
        expect_resp(0, 459, 1'b0);
        expect_resp(3, 42, 1'b0);
        req = 4'b1000;
        wait_resp(100, 1'b0, '0, c);
        req = '0;
        @(negedge clk);
        req = 4'b1001;
        wait_resp(100, 1'b0, '0, c);
        chk("t3_grant0", RW'(grant_id), 0);
        req = '0;
        @(negedge clk);
        req = 4'b1001;
        wait_resp(100, 1'b0, '0, c);
        chk("t3_grant3", RW'(grant_id), 3);
        req = '0;
        @(negedge clk);

        // Fairness: all four held, pointer at 0; a_i=i+2, b_i=10
        for (int i = 0; i < N; i++) set_op(i, W'(i + 2), 10);
        for (int k = 0; k < 5; k++) expect_resp(ord[k], fres[k], 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_resp(100, 1'b0, '0, c);
            chk("t2_grant", RW'(grant_id), RW'(ord[k]));
            if (k == 4) req = '0;
        end
        @(negedge clk);

        // Operand change after grant: 5*7 = 35 even though a0 becomes 99
        set_op(0, 5, 7);
        expect_resp(0, 35, 1'b0);
        req = 4'b0001;
        wait_start(c);
        set_op(0, 99, 7);
        chk("t4_mul_a_issue", RW'(mul_a), 5);
        wait_resp(100, 1'b1, 5, c);
        req = '0;
        @(negedge clk);

        // Timeout: multiplier never acknowledges
        stuck = 1'b1;
        set_op(0, 3, 3);
        expect_resp(0, 0, 1'b1);
        req = 4'b0001;
        wait_start(c);
        wait_resp(TIMEOUT + 100, 1'b0, '0, c);
        req = '0;
        chk("t5_latency", RW'(c), 1025);
        @(negedge clk);
        chk("t5_idle", RW'(busy), 0);
        stuck = 1'b0;
        @(negedge clk);

        // Reset mid-op during WAIT_DONE; no response may appear
        lat = 20;
        set_op(2, 4, 4);
        req = 4'b0100;
        wait_start(c);
        chk("t6_grant2", RW'(grant_id), 2);
        repeat (3) @(negedge clk);
        chk("t6_busy_pre", RW'(busy), 1);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        chk("t6_busy", RW'(busy), 0);
        chk("t6_mul_start", RW'(mul_start), 0);
        chk("t6_resp_valid", RW'(resp_valid), 0);
        chk("t6_grant_id", RW'(grant_id), 0);
        reset = 1'b0;
        lat   = 3;
        @(negedge clk);
        // Pointer back at 0: 0011 grants 0, then 0010 grants 1
        set_op(0, 8, 9);
        set_op(1, 11, 12);
        expect_resp(0, 72, 1'b0);
        expect_resp(1, 132, 1'b0);
        req = 4'b0011;
        wait_resp(100, 1'b0, '0, c);
        req = '0;
        @(negedge clk);
        req = 4'b0010;
        wait_resp(100, 1'b0, '0, c);
        req = '0;

        repeat (10) @(negedge clk);
        chk("queue_empty", RW'(exp_idx.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
